// File: rtl/uart_rx_inbuf_pkg.sv
// rtl/uart_rx_inbuf_pkg.sv - shared types and defaults for the UART input buffer
//
// Purpose: receiver FSM state type plus default frame width and baud divisor
// for the uart_rx_inbuf block and its FIFO.
// Ports: none (package).
package pkg_uart;

  localparam int UART_DATA_W       = 8;
  localparam int UART_CLKS_PER_BIT = 104;  // 12 MHz / 115200

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT
  } rx_state_t;

endpackage

// File: rtl/uart_rx_inbuf_fifo.sv
// rtl/uart_rx_inbuf_fifo.sv - show-ahead byte FIFO behind the UART receiver
//
// Purpose: DEPTH-entry FIFO with registered pointers and an entry count that
// drives empty/full. Head entry is presented combinationally on data_out.
// Ports:
//   clk, rst   clock; synchronous active-high reset
//   push       write push_data (accepted when not full, or when full and popping)
//   push_data  DATA_W-bit entry to write
//   pop        consume head entry; ignored when empty
//   empty      no entries held
//   full       DEPTH entries held
//   count      number of entries held
//   data_out   head entry (mem[rd_ptr])
module rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DATA_W-1:0]        data_out
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign data_out = mem[rd_ptr];

  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // DEPTH is a power of two, so pointer wrap is the natural AW-bit rollover.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_inbuf.sv
// rtl/uart_rx_inbuf.sv - 8N1 UART receiver feeding a show-ahead byte FIFO
//
// Purpose: producer end of the CU input buffer. Deserialises frames from the
// host serial line and queues completed bytes for the CU to read (GETC).
// Ports:
//   clk        clock; all logic rising-edge
//   rst        synchronous, active-high reset
//   rx         asynchronous serial line, idles high
//   pop_front  consume head entry; ignored when empty
//   empty      FIFO holds no entries
//   data_out   head entry, valid while !empty
//   full       FIFO holds DEPTH entries
//   count      current number of entries
//   frame_err  one-cycle pulse: stop bit sampled low
//   overflow   sticky: a completed byte was dropped because the FIFO was full
module uart_rx_inbuf
  import pkg_uart::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DEPTH        = 16,
  parameter int DATA_W       = UART_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx,
  input  logic                   pop_front,
  output logic                   empty,
  output logic [DATA_W-1:0]      data_out,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   frame_err,
  output logic                   overflow
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_W - 1);

  logic              rx_meta;
  logic              rxs;
  rx_state_t         state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [IW-1:0]     idx, idx_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic              push;
  logic              ferr_n;

  // Synchroniser preset high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RX_IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shreg     <= shreg_n;
      frame_err <= ferr_n;
    end
  end

  // The baud counter free-runs down to zero; each state acts on the zero cycle.
  // The start bit is checked at half a bit so data bits are taken mid-bit.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    push    = 1'b0;
    ferr_n  = 1'b0;
    if (cnt != '0) begin
      cnt_n = cnt - 1'b1;
    end
    unique case (state)
      RX_IDLE: begin
        if (!rxs) begin
          state_n = RX_START;
          cnt_n   = HALF_LOAD;
        end
      end
      RX_START: begin
        if (cnt == '0) begin
          if (rxs) begin
            state_n = RX_IDLE;
          end else begin
            state_n = RX_DATA;
            idx_n   = '0;
            cnt_n   = FULL_LOAD;
          end
        end
      end
      RX_DATA: begin
        if (cnt == '0) begin
          shreg_n[idx] = rxs;
          cnt_n        = FULL_LOAD;
          if (idx == LAST_IDX) begin
            state_n = RX_STOP;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      RX_STOP: begin
        if (cnt == '0) begin
          if (rxs) begin
            push    = 1'b1;
            state_n = RX_IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = RX_WAIT;
          end
        end
      end
      RX_WAIT: begin
        // Line held low (break): wait for idle before hunting a new start bit.
        if (rxs) begin
          state_n = RX_IDLE;
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

  // A pop in the push cycle makes room, so only a push into a full FIFO
  // without a pop loses the byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (push && full && !pop_front) begin
      overflow <= 1'b1;
    end
  end

  rx_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shreg_n),
    .pop       (pop_front),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .data_out  (data_out)
  );

endmodule

// File: tb/tb_uart_rx_inbuf.sv
// tb/tb_uart_rx_inbuf.sv - self-checking bench for uart_rx_inbuf
module tb_uart_rx_inbuf;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int DW    = 8;
  // rx falls -> 2 sync flops -> idle detect edge -> half bit -> 8 data + stop bits.
  localparam int PUSH_LAT  = 2 + 1 + CPB / 2 + (DW + 1) * CPB;
  localparam int FRAME_CYC = (DW + 2) * CPB;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic          pop_front;
  logic          empty;
  logic [DW-1:0] data_out;
  logic          full;
  logic [2:0]    count;
  logic          frame_err;
  logic          overflow;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  byte unsigned exp_q[$];
  logic         exp_ovf;

  uart_rx_inbuf #(
    .CLKS_PER_BIT (CPB),
    .DEPTH        (DEPTH),
    .DATA_W       (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .pop_front (pop_front),
    .empty     (empty),
    .data_out  (data_out),
    .full      (full),
    .count     (count),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task tick();
    @(posedge clk);
    #1;
  endtask

  task chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task model_push(input byte unsigned d);
    if (exp_q.size() < DEPTH) exp_q.push_back(d);
    else exp_ovf = 1'b1;
  endtask

  task check_fifo(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(exp_q.size()));
    chk({tag, "_empty"}, 32'(empty), 32'(exp_q.size() == 0));
    chk({tag, "_full"}, 32'(full), 32'(exp_q.size() == DEPTH));
    chk({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    if (exp_q.size() > 0) chk({tag, "_data"}, 32'(data_out), 32'(exp_q[0]));
  endtask

  // Drives start, data bits LSB first and the stop bit; leaves rx at the stop value.
  task send_frame(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < DW; i++) begin
      rx = d[i];
      repeat (CPB) tick();
    end
    rx = stop;
    repeat (CPB) tick();
  endtask

  task recv(input string tag, input logic [7:0] d);
    send_frame(d, 1'b1);
    repeat (PUSH_LAT - FRAME_CYC) tick();
    model_push(d);
    check_fifo(tag);
  endtask

  task pop_one(input string tag);
    if (exp_q.size() > 0) chk({tag, "_head"}, 32'(data_out), 32'(exp_q[0]));
    pop_front = 1'b1;
    tick();
    pop_front = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    check_fifo(tag);
  endtask

  initial begin
    byte unsigned d;
    int k;

    rst = 1'b1;
    rx = 1'b1;
    pop_front = 1'b0;
    exp_ovf = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check_fifo("reset");
    chk("reset_data", 32'(data_out), 32'h0);
    chk("reset_ferr", 32'(frame_err), 32'h0);

    // 1: single frame, exact push latency, pop, pop while empty
    send_frame(8'h41, 1'b1);
    repeat (PUSH_LAT - FRAME_CYC - 1) tick();
    chk("t1_empty_before_push", 32'(empty), 32'h1);
    tick();
    model_push(8'h41);
    check_fifo("t1_after_push");
    pop_one("t1_pop");
    pop_one("t1_pop_empty");

    // 2: half-bit glitch is a false start
    rx = 1'b0;
    repeat (CPB / 2) tick();
    rx = 1'b1;
    repeat (3 * CPB) tick();
    check_fifo("t2_glitch");
    recv("t2_5a", 8'h5A);
    pop_one("t2_pop");

    // 3: bad stop bit, then line held low, then recovery
    send_frame(8'hC3, 1'b0);
    repeat (PUSH_LAT - FRAME_CYC - 1) tick();
    chk("t3_ferr_before", 32'(frame_err), 32'h0);
    tick();
    chk("t3_ferr_pulse", 32'(frame_err), 32'h1);
    tick();
    chk("t3_ferr_after", 32'(frame_err), 32'h0);
    check_fifo("t3_no_push");
    repeat (20) tick();
    chk("t3_ferr_held_low", 32'(frame_err), 32'h0);
    check_fifo("t3_wait");
    rx = 1'b1;
    repeat (CPB) tick();
    recv("t3_01", 8'h01);
    pop_one("t3_pop");

    // 4: fill, overflow, drain
    for (int i = 0; i < 5; i++) recv($sformatf("t4_rx%0d", i), 8'(8'h10 + i));
    for (int i = 0; i < 4; i++) pop_one($sformatf("t4_pop%0d", i));

    // 6: reset in the 4th data bit with a non-empty FIFO and overflow set
    recv("t6_pre", 8'h77);
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 3; i++) begin
      rx = ((8'hA5 >> i) & 8'h01) != 0;
      repeat (CPB) tick();
    end
    rx = 1'b0;
    repeat (CPB / 2) tick();
    rst = 1'b1;
    rx = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    check_fifo("t6_reset");
    chk("t6_reset_data", 32'(data_out), 32'h0);
    chk("t6_reset_ferr", 32'(frame_err), 32'h0);
    repeat (CPB) tick();
    recv("t6_a5", 8'hA5);
    pop_one("t6_pop");

    // 5: full FIFO with a pop in the push cycle, then drain across the wrap
    for (int i = 0; i < DEPTH; i++) begin
      d = 8'($urandom);
      recv($sformatf("t5_fill%0d", i), d);
    end
    d = 8'($urandom);
    send_frame(d, 1'b1);
    repeat (PUSH_LAT - FRAME_CYC - 1) tick();
    chk("t5_head_before", 32'(data_out), 32'(exp_q[0]));
    pop_front = 1'b1;
    tick();
    pop_front = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(d);
    check_fifo("t5_push_pop_full");
    for (int i = 0; i < DEPTH; i++) pop_one($sformatf("t5_drain%0d", i));

    // random frames with random pops between them
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom);
      recv($sformatf("rnd_rx%0d", i), d);
      k = $urandom_range(0, 2);
      for (int j = 0; j < k; j++) pop_one($sformatf("rnd_pop%0d_%0d", i, j));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
